// File: rtl/wb_arbiter2.sv
// Two-master (instruction read-only, data read/write) Wishbone arbiter onto one slave.
// Define WB_ARB_TIMEOUT_EN to abort slave transfers that go unacknowledged for TIMEOUT cycles.
module wb_arbiter2 #(
    parameter int unsigned AW      = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_in,

    input  logic          ib_cyc_i,
    input  logic          ib_stb_i,
    input  logic [AW-1:0] ib_adr_i,
    output logic          ib_ack_o,
    output logic          ib_err_o,
    output logic [31:0]   ib_rdt_o,

    input  logic          db_cyc_i,
    input  logic          db_stb_i,
    input  logic          db_we_i,
    input  logic [3:0]    db_be_i,
    input  logic [AW-1:0] db_adr_i,
    input  logic [31:0]   db_dat_i,
    output logic          db_ack_o,
    output logic          db_err_o,
    output logic [31:0]   db_rdt_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_be_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic          s_ack_i,
    input  logic [31:0]   s_dat_i
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusyI = 2'd1;
    localparam logic [1:0] StBusyD = 2'd2;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("wb_arbiter2: TIMEOUT must be non-zero");
    end

    logic [1:0] state_q, state_d;
    logic       last_d_q, last_d_d;   // 1: data bus held the most recent grant
    logic       ib_req, db_req;
    logic       timeout;

    assign ib_req = ib_cyc_i & ib_stb_i;
    assign db_req = db_cyc_i & db_stb_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Held at zero while idle so every grant starts counting from zero.
    always_comb begin
        cnt_d = '0;
        if (state_q != StIdle && !s_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q != StIdle) && !s_ack_i && (cnt_q == CntW'(TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        unique case (state_q)
            StIdle: begin
                if (ib_req && db_req) begin
                    state_d = last_d_q ? StBusyI : StBusyD;
                end else if (ib_req) begin
                    state_d = StBusyI;
                end else if (db_req) begin
                    state_d = StBusyD;
                end
            end
            StBusyI: begin
                if (s_ack_i || !ib_cyc_i || timeout) begin
                    state_d  = StIdle;
                    last_d_d = 1'b0;
                end
            end
            StBusyD: begin
                if (s_ack_i || !db_cyc_i || timeout) begin
                    state_d  = StIdle;
                    last_d_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobe is masked by ack so a registered-ack slave never sees a second access.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_be_o   = 4'h0;
        s_adr_o  = '0;
        s_dat_o  = 32'h0;
        ib_ack_o = 1'b0;
        ib_err_o = 1'b0;
        db_ack_o = 1'b0;
        db_err_o = 1'b0;
        unique case (state_q)
            StBusyI: begin
                s_cyc_o  = ib_cyc_i & ~timeout;
                s_stb_o  = ib_stb_i & ~s_ack_i & ~timeout;
                s_be_o   = 4'hF;
                s_adr_o  = ib_adr_i;
                ib_ack_o = s_ack_i;
                ib_err_o = timeout;
            end
            StBusyD: begin
                s_cyc_o  = db_cyc_i & ~timeout;
                s_stb_o  = db_stb_i & ~s_ack_i & ~timeout;
                s_we_o   = db_we_i;
                s_be_o   = db_be_i;
                s_adr_o  = db_adr_i;
                s_dat_o  = db_dat_i;
                db_ack_o = s_ack_i;
                db_err_o = timeout;
            end
            default: ;
        endcase
    end

    assign ib_rdt_o = s_dat_i;
    assign db_rdt_o = s_dat_i;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= StIdle;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: transaction-level arbiter model checked every cycle plus directed scenarios.
// Honours WB_ARB_TIMEOUT_EN the same way the design does.
module tb_wb_arbiter2;

    localparam int AW = 10;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_in;
    logic          ib_cyc_i, ib_stb_i;
    logic [AW-1:0] ib_adr_i;
    logic          ib_ack_o, ib_err_o;
    logic [31:0]   ib_rdt_o;
    logic          db_cyc_i, db_stb_i, db_we_i;
    logic [3:0]    db_be_i;
    logic [AW-1:0] db_adr_i;
    logic [31:0]   db_dat_i;
    logic          db_ack_o, db_err_o;
    logic [31:0]   db_rdt_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]    s_be_o;
    logic [AW-1:0] s_adr_o;
    logic [31:0]   s_dat_o;
    logic          s_ack_i;
    logic [31:0]   s_dat_i;

    always #5 clk_i = ~clk_i;

    wb_arbiter2 #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_in(rst_in),
        .ib_cyc_i(ib_cyc_i), .ib_stb_i(ib_stb_i), .ib_adr_i(ib_adr_i),
        .ib_ack_o(ib_ack_o), .ib_err_o(ib_err_o), .ib_rdt_o(ib_rdt_o),
        .db_cyc_i(db_cyc_i), .db_stb_i(db_stb_i), .db_we_i(db_we_i), .db_be_i(db_be_i),
        .db_adr_i(db_adr_i), .db_dat_i(db_dat_i),
        .db_ack_o(db_ack_o), .db_err_o(db_err_o), .db_rdt_o(db_rdt_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
    );

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    // Slave: registered ack one cycle after cyc&stb; inj_ack forces a stray ack.
    logic        ack_q = 1'b0;
    logic        slave_en, inj_ack;
    logic [31:0] slave_data;

    always @(posedge clk_i) ack_q <= slave_en & s_cyc_o & s_stb_o;
    assign s_ack_i = ack_q | inj_ack;
    assign s_dat_i = s_ack_i ? slave_data : 32'h0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_out(
        input logic iack, input logic ierr, input logic dack, input logic derr,
        input logic scyc, input logic sstb, input logic swe, input logic [3:0] sbe,
        input logic [AW-1:0] sadr, input logic [31:0] sdat,
        input logic [31:0] irdt, input logic [31:0] drdt);
        return {11'b0, iack, ierr, dack, derr, scyc, sstb, swe, sbe, sadr, sdat, irdt, drdt};
    endfunction

    // Model state: owner 0 none / 1 ib / 2 db; last 1 ib / 2 db; busy = cycles owned without ack.
    int m_owner = 0;
    int m_last  = 2;
    int m_busy  = 0;

    // Event log: kind 0 ib ack, 1 db ack, 2 ib err, 3 db err.
    int          ev_kind[$];
    int          ev_cyc[$];
    logic [31:0] ev_rdt[$];
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    logic [46:0] acc_fields = '0;

    always @(negedge clk_i) begin : cmp
        logic         to, xcyc;
        logic [127:0] e;
        int           n_owner, n_last, n_busy;
        to = 1'b0;
        n_owner = m_owner;
        n_last  = m_last;
        n_busy  = m_busy;
        e = pack_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0,
                     s_dat_i, s_dat_i);
        if (!rst_in) begin
            n_owner = 0;
            n_last  = 2;
            n_busy  = 0;
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            to = (m_owner != 0) && !s_ack_i && (m_busy == TO);
`endif
            if (m_owner == 1) begin
                e = pack_out(s_ack_i, to, 1'b0, 1'b0, ib_cyc_i & !to,
                             ib_stb_i & !s_ack_i & !to, 1'b0, 4'hF, ib_adr_i, 32'h0,
                             s_dat_i, s_dat_i);
            end else if (m_owner == 2) begin
                e = pack_out(1'b0, 1'b0, s_ack_i, to, db_cyc_i & !to,
                             db_stb_i & !s_ack_i & !to, db_we_i, db_be_i, db_adr_i, db_dat_i,
                             s_dat_i, s_dat_i);
            end
            if (m_owner == 0) begin
                n_busy = 0;
                if (ib_cyc_i && ib_stb_i && db_cyc_i && db_stb_i) n_owner = (m_last == 1) ? 2 : 1;
                else if (ib_cyc_i && ib_stb_i) n_owner = 1;
                else if (db_cyc_i && db_stb_i) n_owner = 2;
            end else begin
                xcyc = (m_owner == 1) ? ib_cyc_i : db_cyc_i;
                if (s_ack_i || !xcyc || to) begin
                    n_owner = 0;
                    n_last  = m_owner;
                end else begin
                    n_busy = m_busy + 1;
                end
            end
        end
        check("cycle_compare",
              pack_out(ib_ack_o, ib_err_o, db_ack_o, db_err_o, s_cyc_o, s_stb_o, s_we_o, s_be_o,
                       s_adr_o, s_dat_o, ib_rdt_o, db_rdt_o), e);
        m_owner <= n_owner;
        m_last  <= n_last;
        m_busy  <= n_busy;
        if (ib_ack_o) begin ev_kind.push_back(0); ev_cyc.push_back(cyc_n); ev_rdt.push_back(ib_rdt_o); end
        if (db_ack_o) begin ev_kind.push_back(1); ev_cyc.push_back(cyc_n); ev_rdt.push_back(db_rdt_o); end
        if (ib_err_o) begin ev_kind.push_back(2); ev_cyc.push_back(cyc_n); ev_rdt.push_back(32'h0); end
        if (db_err_o) begin ev_kind.push_back(3); ev_cyc.push_back(cyc_n); ev_rdt.push_back(32'h0); end
        if (s_cyc_o && s_stb_o) begin
            acc_cnt    <= acc_cnt + 1;
            acc_cyc    <= cyc_n;
            acc_fields <= {s_we_o, s_be_o, s_adr_o, s_dat_o};
        end
    end

    function automatic int count_ev(input int start, input int kind);
        int c = 0;
        for (int i = start; i < ev_kind.size(); i++) if (ev_kind[i] == kind) c++;
        return c;
    endfunction

    function automatic int first_cyc(input int start, input int kind);
        for (int i = start; i < ev_kind.size(); i++) if (ev_kind[i] == kind) return ev_cyc[i];
        return -1;
    endfunction

    function automatic logic [31:0] first_rdt(input int start, input int kind);
        for (int i = start; i < ev_kind.size(); i++) if (ev_kind[i] == kind) return ev_rdt[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_masters();
        ib_cyc_i = 1'b0; ib_stb_i = 1'b0; ib_adr_i = '0;
        db_cyc_i = 1'b0; db_stb_i = 1'b0; db_we_i = 1'b0; db_be_i = 4'h0;
        db_adr_i = '0;   db_dat_i = 32'h0;
    endtask

    task automatic ib_read(input logic [AW-1:0] adr, input logic [31:0] rdata, input string tag);
        int base, n;
        base = ev_kind.size();
        n = cyc_n;
        slave_data = rdata;
        ib_adr_i = adr; ib_cyc_i = 1'b1; ib_stb_i = 1'b1;
        for (int i = 0; i < 8 && !ib_ack_o; i++) tick();
        idle_masters();
        tick(); tick();
        check({tag, "_ack_count"}, 128'(count_ev(base, 0)), 128'(1));
        check({tag, "_ack_latency"}, 128'(first_cyc(base, 0) - n), 128'(2));
        check({tag, "_rdata"}, 128'(first_rdt(base, 0)), 128'(rdata));
    endtask

    initial begin
        int base, n, acc0;
        rst_in = 1'b0; slave_en = 1'b1; inj_ack = 1'b0; slave_data = 32'h0;
        idle_masters();
        repeat (3) tick();
        check("reset_outputs",
              pack_out(ib_ack_o, ib_err_o, db_ack_o, db_err_o, s_cyc_o, s_stb_o, s_we_o, s_be_o,
                       s_adr_o, s_dat_o, ib_rdt_o, db_rdt_o), 128'h0);
        rst_in = 1'b1;
        tick();

        ib_read(10'h010, 32'hDEAD_BEEF, "ib_read");

        // Data write, single slave access, ack two cycles after request.
        base = ev_kind.size(); acc0 = acc_cnt; n = cyc_n;
        db_cyc_i = 1'b1; db_stb_i = 1'b1; db_we_i = 1'b1; db_be_i = 4'b0101;
        db_adr_i = 10'h3FF; db_dat_i = 32'h1122_3344;
        for (int i = 0; i < 8 && !db_ack_o; i++) tick();
        idle_masters();
        tick(); tick();
        check("db_write_accesses", 128'(acc_cnt - acc0), 128'(1));
        check("db_write_access_cycle", 128'(acc_cyc - n), 128'(1));
        check("db_write_fields", 128'(acc_fields), 128'({1'b1, 4'b0101, 10'h3FF, 32'h1122_3344}));
        check("db_write_ack_latency", 128'(first_cyc(base, 1) - n), 128'(2));
        check("db_write_ack_count", 128'(count_ev(base, 1)), 128'(1));

        // Stray ack while idle must not reach either master.
        base = ev_kind.size();
        inj_ack = 1'b1; slave_data = 32'h5555_AAAA;
        tick();
        inj_ack = 1'b0;
        tick();
        check("idle_ack_ignored", 128'(ev_kind.size() - base), 128'(0));

        // Both masters request continuously: I,D,I,D every three cycles.
        base = ev_kind.size(); n = cyc_n; slave_data = 32'h0000_1234;
        ib_adr_i = 10'h020; ib_cyc_i = 1'b1; ib_stb_i = 1'b1;
        db_adr_i = 10'h040; db_cyc_i = 1'b1; db_stb_i = 1'b1;
        repeat (12) tick();
        idle_masters();
        tick(); tick();
        check("alternate_count", 128'(ev_kind.size() - base), 128'(4));
        for (int k = 0; k < 4; k++) begin
            if (base + k < ev_kind.size())
                check($sformatf("alternate_%0d", k),
                      128'({ev_kind[base+k], ev_cyc[base+k] - n}), 128'({k % 2, 2 + 3 * k}));
            else
                check($sformatf("alternate_%0d_missing", k), 128'(0), 128'(1));
        end

        // Leave last grant on ib, then reset in the middle of a data transfer.
        ib_read(10'h155, 32'hCAFE_F00D, "ib_read2");
        db_cyc_i = 1'b1; db_stb_i = 1'b1; db_we_i = 1'b1; db_be_i = 4'hF;
        db_adr_i = 10'h2AA; db_dat_i = 32'hA5A5_A5A5;
        tick();
        check("busy_d_before_reset", 128'({s_cyc_o, s_stb_o, s_we_o}), 128'(3'b111));
        #1 rst_in = 1'b0;
        #1 check("reset_mid_busy",
                 pack_out(ib_ack_o, ib_err_o, db_ack_o, db_err_o, s_cyc_o, s_stb_o, s_we_o,
                          s_be_o, s_adr_o, s_dat_o, ib_rdt_o, db_rdt_o), 128'h0);
        idle_masters();
        tick(); tick();
        rst_in = 1'b1;
        base = ev_kind.size(); n = cyc_n; slave_data = 32'h0BAD_F00D;
        ib_adr_i = 10'h001; ib_cyc_i = 1'b1; ib_stb_i = 1'b1;
        db_adr_i = 10'h002; db_cyc_i = 1'b1; db_stb_i = 1'b1;
        for (int i = 0; i < 8 && !ib_ack_o && !db_ack_o; i++) tick();
        idle_masters();
        tick(); tick();
        if (base < ev_kind.size())
            check("post_reset_ib_first", 128'({ev_kind[base], ev_cyc[base] - n}), 128'({0, 2}));
        else
            check("post_reset_ib_first_missing", 128'(0), 128'(1));

        // Slave never acks.
        slave_en = 1'b0;
        base = ev_kind.size(); n = cyc_n;
        db_cyc_i = 1'b1; db_stb_i = 1'b1; db_adr_i = 10'h0AA;
        repeat (12) tick();
`ifdef WB_ARB_TIMEOUT_EN
        check("timeout_err_count", 128'(count_ev(base, 3)), 128'(2));
        check("timeout_first_err", 128'(first_cyc(base, 3) - n), 128'(TO + 1));
`else
        check("no_timeout_err", 128'(count_ev(base, 2) + count_ev(base, 3)), 128'(0));
        check("no_timeout_pending", 128'({s_cyc_o, s_stb_o}), 128'(2'b11));
`endif
        check("no_ack_without_slave", 128'(count_ev(base, 1)), 128'(0));
        idle_masters();
        tick();
        check("cyc_drop_released", 128'(s_cyc_o), 128'(0));
        slave_en = 1'b1;
        tick();
        ib_read(10'h3C3, 32'h1357_9BDF, "ib_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
